riscv_proc_ll_wb_arb: RTL and testbench

Long-latency writeback arbiter and scoreboard for the baseline integer pipeline. Merges result streams from the data cache, the multiply/divide unit and the FPU (integer-destination results) onto the register file's single long-latency write port (`ll_waddr`/`ll_wen`/`ll_wdata`). Tracks every integer register with an outstanding long-latency write and raises a decode-stage interlock for RAW and WAW hazards against it.

---
 rtl/riscv_proc_ll_wb_arb.sv | 141 ++++++++++++++
 tb/tb_riscv_proc_ll_wb_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_proc_ll_wb_arb.sv
// Long-latency writeback arbiter and integer scoreboard: merges mem/mdu/fpu results onto ll_* port.
// Optional FPU participation enabled by macro RISCV_LL_FPU_EN.
module riscv_proc_ll_wb_arb #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_wen,
  input  logic [4:0]        issue_waddr,
  input  logic [4:0]        id_raddr1,
  input  logic [4:0]        id_raddr2,
  input  logic              id_ren1,
  input  logic              id_ren2,
  input  logic [4:0]        id_waddr,
  input  logic              id_wen,
  input  logic              mem_resp_val,
  input  logic [4:0]        mem_resp_waddr,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mdu_resp_val,
  output logic              mdu_resp_rdy,
  input  logic [4:0]        mdu_resp_waddr,
  input  logic [DATA_W-1:0] mdu_resp_data,
  input  logic              fpu_resp_val,
  output logic              fpu_resp_rdy,
  input  logic [4:0]        fpu_resp_waddr,
  input  logic [DATA_W-1:0] fpu_resp_data,
  output logic              ll_wen,
  output logic [4:0]        ll_waddr,
  output logic [DATA_W-1:0] ll_wdata,
  output logic              ll_stall,
  output logic              sb_busy,
  output logic              sb_error
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic [NREG-1:0]   sb;
  logic [NREG-1:0]   sb_nxt;
  logic              mdu_win;
  logic              fpu_win;
  logic              acc_val;
  logic [AW-1:0]     acc_waddr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_err;

`ifdef RISCV_LL_FPU_EN
  // last = 0: mdu granted most recently; reset to 1 so mdu wins the first tie
  logic last;

  always_comb begin
    mdu_win = 1'b0;
    fpu_win = 1'b0;
    if (!reset && !mem_resp_val) begin
      mdu_win = mdu_resp_val && (!fpu_resp_val || last);
      fpu_win = fpu_resp_val && (!mdu_resp_val || !last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (mdu_win) begin
      last <= 1'b0;
    end else if (fpu_win) begin
      last <= 1'b1;
    end
  end
`else
  logic unused_fpu;
  assign unused_fpu = ^{fpu_resp_val, fpu_resp_waddr, fpu_resp_data};

  always_comb begin
    mdu_win = !reset && !mem_resp_val && mdu_resp_val;
    fpu_win = 1'b0;
  end
`endif

  assign mdu_resp_rdy = mdu_win;
  assign fpu_resp_rdy = fpu_win;

  // Select the accepted response; mem needs no handshake and is never refused outside reset
  always_comb begin
    acc_val   = 1'b0;
    acc_waddr = '0;
    acc_data  = '0;
    if (!reset && mem_resp_val) begin
      acc_val   = 1'b1;
      acc_waddr = mem_resp_waddr;
      acc_data  = mem_resp_data;
    end else if (mdu_win) begin
      acc_val   = 1'b1;
      acc_waddr = mdu_resp_waddr;
      acc_data  = mdu_resp_data;
    end else if (fpu_win) begin
      acc_val   = 1'b1;
      acc_waddr = fpu_resp_waddr;
      acc_data  = fpu_resp_data;
    end
  end

  assign acc_err = acc_val && (acc_waddr != '0) && !sb[acc_waddr];

  // Clear for the write in flight, then set for the new issue so a same-address set wins
  always_comb begin
    sb_nxt = sb;
    if (ll_wen) begin
      sb_nxt[ll_waddr] = 1'b0;
    end
    if (issue_wen) begin
      sb_nxt[issue_waddr] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb       <= '0;
      ll_wen   <= 1'b0;
      ll_waddr <= '0;
      ll_wdata <= '0;
      sb_error <= 1'b0;
    end else begin
      sb     <= sb_nxt;
      ll_wen <= acc_val && (acc_waddr != '0);
      if (acc_val) begin
        ll_waddr <= acc_waddr;
        ll_wdata <= acc_data;
      end
      if (acc_err) begin
        sb_error <= 1'b1;
      end
    end
  end

  assign sb_busy  = |sb;
  assign ll_stall = (id_ren1 && sb[id_raddr1]) ||
                    (id_ren2 && sb[id_raddr2]) ||
                    (id_wen  && sb[id_waddr]);

endmodule

// File: tb/tb_riscv_proc_ll_wb_arb.sv
// Scoreboard bench for riscv_proc_ll_wb_arb: expected writebacks queued at acceptance, checked by a monitor.
module tb_riscv_proc_ll_wb_arb;

  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_wen;
  logic [4:0]        issue_waddr;
  logic [4:0]        id_raddr1, id_raddr2, id_waddr;
  logic              id_ren1, id_ren2, id_wen;
  logic              mem_resp_val;
  logic [4:0]        mem_resp_waddr;
  logic [DATA_W-1:0] mem_resp_data;
  logic              mdu_resp_val, mdu_resp_rdy;
  logic [4:0]        mdu_resp_waddr;
  logic [DATA_W-1:0] mdu_resp_data;
  logic              fpu_resp_val, fpu_resp_rdy;
  logic [4:0]        fpu_resp_waddr;
  logic [DATA_W-1:0] fpu_resp_data;
  logic              ll_wen;
  logic [4:0]        ll_waddr;
  logic [DATA_W-1:0] ll_wdata;
  logic              ll_stall, sb_busy, sb_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]        exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  riscv_proc_ll_wb_arb #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .issue_wen(issue_wen), .issue_waddr(issue_waddr),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_ren1(id_ren1), .id_ren2(id_ren2),
    .id_waddr(id_waddr), .id_wen(id_wen),
    .mem_resp_val(mem_resp_val), .mem_resp_waddr(mem_resp_waddr), .mem_resp_data(mem_resp_data),
    .mdu_resp_val(mdu_resp_val), .mdu_resp_rdy(mdu_resp_rdy),
    .mdu_resp_waddr(mdu_resp_waddr), .mdu_resp_data(mdu_resp_data),
    .fpu_resp_val(fpu_resp_val), .fpu_resp_rdy(fpu_resp_rdy),
    .fpu_resp_waddr(fpu_resp_waddr), .fpu_resp_data(fpu_resp_data),
    .ll_wen(ll_wen), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .ll_stall(ll_stall), .sb_busy(sb_busy), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [DATA_W-1:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Monitor: every ll_wen cycle must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (ll_wen === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wb: got waddr %0d data %h, expected no write at %0t", ll_waddr, ll_wdata, $time);
        end else begin
          chk("wb_addr", 64'(ll_waddr), 64'(exp_addr_q.pop_front()));
          chk("wb_data", ll_wdata, exp_data_q.pop_front());
        end
      end
`ifndef RISCV_LL_FPU_EN
      if (fpu_resp_val === 1'b1) chk("fpu_rdy_tied0", 64'(fpu_resp_rdy), 64'(0));
`endif
    end
  end

  task automatic idle();
    issue_wen = 1'b0; issue_waddr = '0;
    id_raddr1 = '0; id_raddr2 = '0; id_waddr = '0;
    id_ren1 = 1'b0; id_ren2 = 1'b0; id_wen = 1'b0;
    mem_resp_val = 1'b0; mem_resp_waddr = '0; mem_resp_data = '0;
    mdu_resp_val = 1'b0; mdu_resp_waddr = '0; mdu_resp_data = '0;
    fpu_resp_val = 1'b0; fpu_resp_waddr = '0; fpu_resp_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    step();
    idle();
    issue_wen = 1'b1;
    issue_waddr = a;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ll_wen", 64'(ll_wen), 64'(0));
    chk("rst_ll_waddr", 64'(ll_waddr), 64'(0));
    chk("rst_ll_wdata", ll_wdata, 64'(0));
    chk("rst_stall", 64'(ll_stall), 64'(0));
    chk("rst_busy", 64'(sb_busy), 64'(0));
    chk("rst_error", 64'(sb_error), 64'(0));

    // Basic RAW interlock on r5
    issue(5'd5);
    for (int i = 0; i < 3; i++) begin
      step(); idle(); id_ren1 = 1'b1; id_raddr1 = 5'd5;
      @(negedge clk);
      chk("raw_stall_wait", 64'(ll_stall), 64'(1));
      chk("raw_busy_wait", 64'(sb_busy), 64'(1));
    end
    step(); idle(); id_ren1 = 1'b1; id_raddr1 = 5'd5;
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd5; mdu_resp_data = 64'h1234;
    expect_wb(5'd5, 64'h1234);
    @(negedge clk);
    chk("raw_mdu_rdy", 64'(mdu_resp_rdy), 64'(1));
    chk("raw_stall_acc", 64'(ll_stall), 64'(1));
    step(); idle(); id_ren1 = 1'b1; id_raddr1 = 5'd5;
    @(negedge clk);
    chk("raw_ll_wen", 64'(ll_wen), 64'(1));
    chk("raw_stall_wb", 64'(ll_stall), 64'(1));
    step(); idle(); id_ren1 = 1'b1; id_raddr1 = 5'd5;
    @(negedge clk);
    chk("raw_stall_done", 64'(ll_stall), 64'(0));
    chk("raw_busy_done", 64'(sb_busy), 64'(0));
    chk("raw_wen_done", 64'(ll_wen), 64'(0));

    // Priority: mem, then mdu, then fpu
    do_reset();
    issue(5'd3); issue(5'd4); issue(5'd6);
    step(); idle();
    mem_resp_val = 1'b1; mem_resp_waddr = 5'd3; mem_resp_data = 64'hAAAA;
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd4; mdu_resp_data = 64'hBBBB;
    fpu_resp_val = 1'b1; fpu_resp_waddr = 5'd6; fpu_resp_data = 64'hCCCC;
    expect_wb(5'd3, 64'hAAAA);
    @(negedge clk);
    chk("prio_mdu_rdy_mem", 64'(mdu_resp_rdy), 64'(0));
    chk("prio_fpu_rdy_mem", 64'(fpu_resp_rdy), 64'(0));
    step(); mem_resp_val = 1'b0;
    expect_wb(5'd4, 64'hBBBB);
    @(negedge clk);
    chk("prio_mdu_rdy", 64'(mdu_resp_rdy), 64'(1));
    chk("prio_fpu_rdy_lose", 64'(fpu_resp_rdy), 64'(0));
    step(); mdu_resp_val = 1'b0;
`ifdef RISCV_LL_FPU_EN
    expect_wb(5'd6, 64'hCCCC);
    @(negedge clk);
    chk("prio_fpu_rdy", 64'(fpu_resp_rdy), 64'(1));
`else
    @(negedge clk);
`endif
    step(); idle();
    step();

    // Round-robin fairness, mdu first after reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(); idle();
      mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd10; mdu_resp_data = 64'h100 + 64'(i);
      fpu_resp_val = 1'b1; fpu_resp_waddr = 5'd20; fpu_resp_data = 64'h200 + 64'(i);
`ifdef RISCV_LL_FPU_EN
      if (i % 2 == 0) expect_wb(5'd10, 64'h100 + 64'(i));
      else            expect_wb(5'd20, 64'h200 + 64'(i));
      @(negedge clk);
      chk("rr_mdu_rdy", 64'(mdu_resp_rdy), 64'(i % 2 == 0));
      chk("rr_fpu_rdy", 64'(fpu_resp_rdy), 64'(i % 2 == 1));
`else
      expect_wb(5'd10, 64'h100 + 64'(i));
      @(negedge clk);
      chk("rr_mdu_rdy", 64'(mdu_resp_rdy), 64'(1));
`endif
    end
    step(); idle();
    step();

    // Simultaneous set and clear on r7
    do_reset();
    issue(5'd7);
    step(); idle();
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd7; mdu_resp_data = 64'h77;
    expect_wb(5'd7, 64'h77);
    step(); idle();
    issue_wen = 1'b1; issue_waddr = 5'd7; id_ren2 = 1'b1; id_raddr2 = 5'd7;
    @(negedge clk);
    chk("setclr_stall_same", 64'(ll_stall), 64'(1));
    step(); idle(); id_ren2 = 1'b1; id_raddr2 = 5'd7;
    @(negedge clk);
    chk("setclr_stall_after", 64'(ll_stall), 64'(1));
    chk("setclr_busy", 64'(sb_busy), 64'(1));
    chk("setclr_no_err", 64'(sb_error), 64'(0));
    // WAW interlock against the still-pending r7
    id_ren2 = 1'b0; id_wen = 1'b1; id_waddr = 5'd7;
    #1;
    chk("waw_stall", 64'(ll_stall), 64'(1));
    id_waddr = 5'd8;
    #1;
    chk("waw_other", 64'(ll_stall), 64'(0));

    // Error on unexpected response, sticky
    do_reset();
    step(); idle();
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd9; mdu_resp_data = 64'h99;
    expect_wb(5'd9, 64'h99);
    @(negedge clk);
    chk("err_before", 64'(sb_error), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step(); idle();
      @(negedge clk);
      chk("err_sticky", 64'(sb_error), 64'(1));
    end

    // r0 response consumed without write or error
    do_reset();
    step(); idle();
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd0; mdu_resp_data = 64'hFF;
    @(negedge clk);
    chk("r0_rdy", 64'(mdu_resp_rdy), 64'(1));
    step(); idle();
    @(negedge clk);
    chk("r0_no_wen", 64'(ll_wen), 64'(0));
    chk("r0_no_err", 64'(sb_error), 64'(0));

    // Reset mid-flight with pending registers and a queued write
    do_reset();
    issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
    step(); idle();
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd4; mdu_resp_data = 64'h44;
    expect_wb(5'd4, 64'h44);
    step(); idle();
    reset = 1'b1;
    mdu_resp_val = 1'b1; mdu_resp_waddr = 5'd1; mdu_resp_data = 64'h11;
    mem_resp_val = 1'b0;
    @(negedge clk);
    chk("midrst_rdy", 64'(mdu_resp_rdy), 64'(0));
    step(); idle(); reset = 1'b0;
    id_ren1 = 1'b1; id_raddr1 = 5'd1;
    @(negedge clk);
    chk("midrst_busy", 64'(sb_busy), 64'(0));
    chk("midrst_wen", 64'(ll_wen), 64'(0));
    chk("midrst_waddr", 64'(ll_waddr), 64'(0));
    chk("midrst_stall", 64'(ll_stall), 64'(0));
    step(); idle();
    step();
    @(negedge clk);

    chk("queue_drained", 64'(exp_addr_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
